// File: rtl/if_id_queue_pkg.sv
// Shared widths, default queue depth and small helpers for the IF/ID instruction queue.
package if_id_queue_pkg;

    localparam int INST_ADDR_BUS  = 32;
    localparam int INST_BUS       = 32;
    localparam int IF_QUEUE_DEPTH = 4;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Encodes {push, pop} so the occupancy update can be a single case.
    typedef enum logic [1:0] {
        Q_IDLE = 2'b00,
        Q_POP  = 2'b01,
        Q_PUSH = 2'b10,
        Q_BOTH = 2'b11
    } q_op_e;

endpackage

// File: rtl/if_id_queue_mem.sv
// Register array with synchronous write and asynchronous read; data carries no reset.
module if_id_queue_mem #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Entry write on accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry circular instruction buffer between IF and ID with flush and global rdy freeze.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_BUS,
    parameter int INST_W = INST_BUS,
    parameter int DEPTH  = IF_QUEUE_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic                     if_valid,
    input  logic [ADDR_W-1:0]        if_pc,
    input  logic [INST_W-1:0]        if_inst,
    output logic                     if_ready,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [ADDR_W-1:0]        id_pc,
    output logic [INST_W-1:0]        id_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + INST_W;

    logic [PTR_W-1:0] wp_r;
    logic [PTR_W-1:0] rp_r;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    q_op_e            op_s;
    logic [ENT_W-1:0] head_s;

    assign full_s   = (count_r == CNT_W'(DEPTH));
    assign empty_s  = (count_r == {CNT_W{1'b0}});
    assign if_ready = rdy && !flush && !full_s;
    assign id_valid = rdy && !empty_s;
    assign push_s   = if_valid && if_ready;
    assign pop_s    = id_valid && id_ready && !flush;
    assign op_s     = q_op_e'({push_s, pop_s});
    assign count    = count_r;

    if_id_queue_mem #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wp_r),
        .wdata ({if_pc, if_inst}),
        .raddr (rp_r),
        .rdata (head_s)
    );

    // Pointer and occupancy state; flush wins over any concurrent push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_r    <= {PTR_W{1'b0}};
            rp_r    <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (rdy) begin
            if (flush) begin
                wp_r    <= {PTR_W{1'b0}};
                rp_r    <= {PTR_W{1'b0}};
                count_r <= {CNT_W{1'b0}};
            end else begin
                case (op_s)
                    Q_PUSH: begin
                        wp_r    <= wp_r + PTR_W'(1);
                        count_r <= count_r + CNT_W'(1);
                    end
                    Q_POP: begin
                        rp_r    <= rp_r + PTR_W'(1);
                        count_r <= count_r - CNT_W'(1);
                    end
                    Q_BOTH: begin
                        wp_r <= wp_r + PTR_W'(1);
                        rp_r <= rp_r + PTR_W'(1);
                    end
                    default: begin
                        wp_r    <= wp_r;
                        rp_r    <= rp_r;
                        count_r <= count_r;
                    end
                endcase
            end
        end
    end

    // Head view for ID; an empty queue presents a zero bubble rather than stale storage.
    always_comb begin
        id_pc   = ADDR_W'(ZERO_WORD);
        id_inst = INST_W'(ZERO_WORD);
        if (empty_s) begin
            id_pc   = ADDR_W'(ZERO_WORD);
            id_inst = INST_W'(ZERO_WORD);
        end else begin
            id_pc   = head_s[ENT_W-1:INST_W];
            id_inst = head_s[INST_W-1:0];
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Randomised plus directed bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t mq[$];

    if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .flush    (flush),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .id_valid (id_valid),
        .id_ready (id_ready),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return pc ^ 32'h0013_A5A5;
    endfunction

    // Reference model: a plain FIFO updated from the inputs seen at each rising edge.
    always @(posedge clk) begin
        if (!rst) begin
            mq.delete();
        end else if (rdy) begin
            if (flush) begin
                mq.delete();
            end else begin
                bit do_push;
                bit do_pop;
                ent_t e;
                do_push = if_valid && (mq.size() < DEPTH);
                do_pop  = id_ready && (mq.size() != 0);
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    e.pc   = if_pc;
                    e.inst = if_inst;
                    mq.push_back(e);
                end
            end
        end
    end

    always @(negedge rst) mq.delete();

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        logic [31:0] epc;
        logic [31:0] einst;
        epc   = 32'h0;
        einst = 32'h0;
        if (mq.size() != 0) begin
            epc   = mq[0].pc;
            einst = mq[0].inst;
        end
        chk("count",    64'(count),    64'(mq.size()));
        chk("if_ready", 64'(if_ready), 64'(rdy && !flush && (mq.size() < DEPTH)));
        chk("id_valid", 64'(id_valid), 64'(rdy && (mq.size() != 0)));
        chk("id_pc",    64'(id_pc),    64'(epc));
        chk("id_inst",  64'(id_inst),  64'(einst));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid = 1'b0;
        id_ready = 1'b0;
        flush    = 1'b0;
        rdy      = 1'b1;
    endtask

    task automatic push_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            if_valid = 1'b1;
            if_pc    = base + 32'(4 * i);
            if_inst  = word_of(if_pc);
            step();
        end
        if_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        if_pc = 32'h0;
        if_inst = 32'h0;
        idle();
        repeat (3) step();
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_id_valid", 64'(id_valid), 64'd0);
        chk("reset_id_pc", 64'(id_pc), 64'd0);
        chk("reset_if_ready", 64'(if_ready), 64'd1);
        rst = 1'b1;
        step();

        // Fill to full with ID stalled.
        push_n(4, 32'h0);
        #1;
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_if_ready", 64'(if_ready), 64'd0);
        chk("fill_id_pc", 64'(id_pc), 64'h0);
        chk("fill_id_inst", 64'(id_inst), 64'(32'h0013_A5A5));

        // Drain in order.
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", 64'(id_pc), 64'(32'(4 * i)));
            step();
        end
        id_ready = 1'b0;
        #1;
        chk("drain_empty_valid", 64'(id_valid), 64'd0);
        chk("drain_empty_pc", 64'(id_pc), 64'd0);
        chk("drain_empty_inst", 64'(id_inst), 64'd0);

        // Streaming, wrapping pointers several times.
        if_valid = 1'b1;
        id_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if_pc   = 32'h100 + 32'(4 * i);
            if_inst = word_of(if_pc);
            step();
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_pc", 64'(id_pc), 64'(32'h100 + 32'(4 * i)));
        end
        if_valid = 1'b0;
        step();
        id_ready = 1'b0;

        // Flush with a concurrent push.
        push_n(3, 32'h180);
        chk("pre_flush_count", 64'(count), 64'd3);
        flush    = 1'b1;
        if_valid = 1'b1;
        if_pc    = 32'h200;
        if_inst  = word_of(32'h200);
        #1;
        chk("flush_if_ready", 64'(if_ready), 64'd0);
        step();
        flush    = 1'b0;
        if_valid = 1'b0;
        #1;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_id_valid", 64'(id_valid), 64'd0);
        push_n(1, 32'h300);
        #1;
        chk("post_flush_head", 64'(id_pc), 64'h300);
        chk("post_flush_count", 64'(count), 64'd1);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;

        // rdy freeze with both handshakes requested.
        push_n(2, 32'h400);
        rdy      = 1'b0;
        if_valid = 1'b1;
        id_ready = 1'b1;
        if_pc    = 32'h500;
        if_inst  = word_of(32'h500);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("freeze_count", 64'(count), 64'd2);
            chk("freeze_id_valid", 64'(id_valid), 64'd0);
            chk("freeze_id_pc", 64'(id_pc), 64'h400);
        end
        rdy = 1'b1;
        step();
        chk("resume_id_pc", 64'(id_pc), 64'h404);
        step();
        idle();
        step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if_valid = ($urandom_range(0, 99) < 60);
            id_ready = ($urandom_range(0, 99) < 55);
            flush    = ($urandom_range(0, 99) < 4);
            rdy      = ($urandom_range(0, 99) < 90);
            if_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if_inst  = $urandom();
            step();
        end
        idle();
        step();

        // Asynchronous reset between edges with entries present.
        push_n(3, 32'h600);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_id_pc", 64'(id_pc), 64'd0);
        chk("async_rst_id_inst", 64'(id_inst), 64'd0);
        chk("async_rst_id_valid", 64'(id_valid), 64'd0);
        step();
        rst = 1'b1;
        push_n(2, 32'h700);
        #1;
        chk("after_rst_head", 64'(id_pc), 64'h700);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised instruction buffer between the IF and ID stages. It generalises the single-entry IF/ID pipeline register into a DEPTH-entry circular FIFO with valid/ready handshakes on both sides, a single-cycle flush for branch redirects, and a global `rdy` freeze. IF can prefetch ahead while ID is stalled. ID sees a zero bubble (pc = 0, inst = 0) whenever the queue is empty.

## Interface
- ADDR_W, 32, width of instruction address
- INST_W, 32, width of instruction word
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global ready; low freezes all state
- flush  in  1  discard all entries (branch/jump redirect from ctrl)
- if_valid  in  1  IF presents an instruction
- if_pc  in  ADDR_W  address of presented instruction
- if_inst  in  INST_W  presented instruction word
- if_ready  out  1  queue accepts a push this cycle
- id_valid  out  1  head entry available to ID
- id_ready  in  1  ID consumes head this cycle
- id_pc  out  ADDR_W  head address, 0 when empty
- id_inst  out  INST_W  head instruction, 0 when empty
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage is DEPTH × (ADDR_W+INST_W), with write pointer `wp` and read pointer `rp`.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- `count` is tracked explicitly. It is not derived from the pointers, so full and empty are unambiguous.
- if_ready = rdy && !flush && (count < DEPTH).
- push = if_valid && if_ready. On push, the entry is written at `wp` and `wp` increments.
- id_valid = rdy && (count != 0).
- pop = id_valid && id_ready && !flush. On pop, `rp` increments.
- count_next = count + push − pop.
  - Simultaneous push and pop leaves count unchanged.
- Full queue: if_ready = 0 even if a pop occurs in the same cycle. There is no full-cycle pass-through.
- Empty queue:
  - id_pc = 0 and id_inst = 0 (bubble).
  - A push while empty is not bypassed to ID.
- flush has priority over everything:
  - wp, rp and count go to 0 next cycle.
  - A concurrent push or pop is discarded.
  - Storage contents need not be cleared.
- rdy = 0:
  - No push, no pop, no flush effect; all registers hold.
  - id_valid = 0, while id_pc and id_inst keep showing the head entry.
- id_pc and id_inst are read combinationally from the head (storage at `rp`), gated to zero when count == 0.
- Reset (rst = 0, asynchronous): wp = rp = count = 0, so id_valid = 0, id_pc = 0, id_inst = 0, and if_ready = 1 once rst = 1 and rdy = 1.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.

## Timing
- Minimum latency from push to id_valid is 1 cycle.
- Throughput: 1 push and 1 pop per cycle sustained when 0 < count < DEPTH.
- if_ready and id_valid are combinational only from count, rdy and flush; neither depends on if_valid or id_ready.
- flush asserted in cycle N: if_ready = 0 in N; id_valid = 0 from N+1; the first post-flush push is accepted in N+1.
- Deassertion of rst is sampled synchronously at the first rising edge where rst = 1.

## Structure
- Add `InstAddrBus`/`InstBus`-style width defines for ADDR_W and INST_W defaults to the shared defines file.
- Add `IfQueueDepth` (default 4) to the same shared defines file.
- The bubble value reuses `ZeroWord`.
- One natural sub-module: `if_id_queue_mem`. It is a synchronous-write, asynchronous-read register array parametrised by WIDTH and DEPTH, with no reset on the data.
- Pointer, count and handshake logic stay in `if_id_queue`.
- ctrl drives `flush` from its branch-redirect signal, replacing the per-stage stall_sign bits for this stage.

## Test plan
- Reset then fill: push pc 0x00,0x04,0x08,0x0C with id_ready = 0 → count = 4, if_ready = 0, id_pc = 0x00, id_inst equals the first word.
- Drain order: from full, id_ready = 1 for 4 cycles → id_pc sequence is 0x00,0x04,0x08,0x0C, then id_valid = 0 and id_pc = id_inst = 0.
- Streaming: if_valid = id_ready = 1 continuously, pushing 0x100 onward → after 1-cycle fill, one pop per cycle, count stays 1, and pointers wrap past DEPTH with no loss.
- Flush with push: count = 3, then flush = 1 while if_valid = 1 (pc 0x200) → next cycle count = 0 and id_valid = 0; a push of 0x300 the following cycle appears as head.
- rdy freeze: count = 2, rdy = 0 for 3 cycles while if_valid = id_ready = 1 → count stays 2, id_valid = 0, pointers unchanged; resumes correctly when rdy = 1.
- Async reset mid-stream: assert rst = 0 between clock edges with count = 3 → count = 0 and id_pc = id_inst = 0 immediately, with no clock edge required.
